adc_capture: RTL and testbench



---
 rtl/adc_capture.sv | 239 +++++++++++++++++++++++
 tb/tb_adc_capture.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - threshold-triggered multi-channel ADC capture buffer with AXI-Stream readout
module adc_capture #(
    parameter int N_CH         = 2,
    parameter int SAMPLE_WIDTH = 16,
    parameter int PARALLEL     = 16,
    parameter int DEPTH        = 512,
    localparam int AW          = $clog2(DEPTH),
    localparam int CW          = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int WW          = PARALLEL * SAMPLE_WIDTH
) (
    input  logic                 s0_axis_adc_aclk,
    input  logic                 s0_axis_adc_aresetn,
    input  logic [N_CH*WW-1:0]   s_axis_adc_tdata,
    input  logic                 s_axis_adc_tvalid,
    output logic                 s_axis_adc_tready,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [SAMPLE_WIDTH-1:0] threshold,
    input  logic [CW-1:0]        trig_ch,
    input  logic [AW-1:0]        pretrig,
    output logic [WW-1:0]        m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic                 busy,
    output logic                 triggered,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_ARMED,
        S_POST,
        S_READOUT
    } state_t;

    state_t state;

    // Per-channel circular sample buffers; contents are never reset.
    logic [WW-1:0] mem [N_CH][DEPTH];

    // Capture-side registers
    logic [AW-1:0]                 wr_ptr;
    logic [AW-1:0]                 start_ptr;
    logic [AW:0]                   count;
    logic [AW-1:0]                 pretrig_q;
    logic signed [SAMPLE_WIDTH-1:0] thr_q;
    logic [CW-1:0]                 trig_ch_q;

    // Readout pipeline: issue counters, RAM read register, output register
    logic [AW-1:0] rd_word;
    logic [CW-1:0] rd_ch;
    logic          rd_all;
    logic          r_valid;
    logic          r_last;
    logic [WW-1:0] ram_q;

    logic          wr_en;
    logic          hit;
    logic [WW-1:0] trig_word;
    logic          out_load;
    logic          issue;
    logic          final_hs;
    logic [AW:0]   post_len;
    logic [AW:0]   count_inc;
    logic [AW-1:0] rd_addr;
    logic          issue_last;

    // Beats are stored in every capture state; an abort cycle stores nothing.
    assign wr_en = s_axis_adc_tvalid && !abort &&
                   (state == S_PREFILL || state == S_ARMED || state == S_POST);

    // Words still to be stored after the pre-trigger section, trigger word included.
    assign post_len  = (AW+1)'(DEPTH) - {1'b0, pretrig_q};
    assign count_inc = count + 1'b1;
    assign rd_addr   = start_ptr + rd_word;

    // The output register accepts a new word whenever it is empty or being consumed.
    assign out_load   = !m_axis_tvalid || m_axis_tready;
    assign issue      = (state == S_READOUT) && !rd_all && !abort && (!r_valid || out_load);
    assign final_hs   = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign issue_last = (rd_ch == CW'(N_CH - 1)) && (rd_word == AW'(DEPTH - 1));

    assign busy = (state != S_IDLE);

    // Select the latched trigger channel out of the incoming beat.
    always_comb begin
        trig_word = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (trig_ch_q == CW'(c)) begin
                trig_word = s_axis_adc_tdata[c*WW +: WW];
            end
        end
    end

    // Any sample of the trigger channel strictly above the signed threshold.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < PARALLEL; i++) begin
            if ($signed(trig_word[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]) > thr_q) begin
                hit = 1'b1;
            end
        end
    end

    // Buffer write of all channels and registered readout read.
    always_ff @(posedge s0_axis_adc_aclk) begin
        if (wr_en) begin
            for (int c = 0; c < N_CH; c++) begin
                mem[c][wr_ptr] <= s_axis_adc_tdata[c*WW +: WW];
            end
        end
        if (issue) begin
            ram_q <= mem[rd_ch][rd_addr];
        end
    end

    // Capture/readout state machine with registered outputs.
    always_ff @(posedge s0_axis_adc_aclk or negedge s0_axis_adc_aresetn) begin
        if (!s0_axis_adc_aresetn) begin
            state             <= S_IDLE;
            s_axis_adc_tready <= 1'b0;
            m_axis_tdata      <= '0;
            m_axis_tvalid     <= 1'b0;
            m_axis_tlast      <= 1'b0;
            triggered         <= 1'b0;
            done              <= 1'b0;
            wr_ptr            <= '0;
            start_ptr         <= '0;
            count             <= '0;
            pretrig_q         <= '0;
            thr_q             <= '0;
            trig_ch_q         <= '0;
            rd_word           <= '0;
            rd_ch             <= '0;
            rd_all            <= 1'b0;
            r_valid           <= 1'b0;
            r_last            <= 1'b0;
        end else begin
            s_axis_adc_tready <= 1'b1;
            done              <= 1'b0;
            if (abort) begin
                state         <= S_IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                triggered     <= 1'b0;
                r_valid       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (arm) begin
                            // The AW-bit pretrig port cannot exceed DEPTH-1.
                            pretrig_q <= pretrig;
                            thr_q     <= threshold;
                            trig_ch_q <= (int'(trig_ch) >= N_CH) ? '0 : trig_ch;
                            wr_ptr    <= '0;
                            count     <= '0;
                            triggered <= 1'b0;
                            state     <= (pretrig == '0) ? S_ARMED : S_PREFILL;
                        end
                    end
                    S_PREFILL: begin
                        if (s_axis_adc_tvalid) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            count  <= count_inc;
                            if (count_inc == {1'b0, pretrig_q}) begin
                                state <= S_ARMED;
                            end
                        end
                    end
                    S_ARMED: begin
                        if (s_axis_adc_tvalid) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (hit) begin
                                start_ptr <= wr_ptr - pretrig_q;
                                triggered <= 1'b1;
                                count     <= (AW+1)'(1);
                                rd_word   <= '0;
                                rd_ch     <= '0;
                                rd_all    <= 1'b0;
                                r_valid   <= 1'b0;
                                state     <= (post_len == (AW+1)'(1)) ? S_READOUT : S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (s_axis_adc_tvalid) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            count  <= count_inc;
                            if (count_inc == post_len) begin
                                state <= S_READOUT;
                            end
                        end
                    end
                    S_READOUT: begin
                        // Read stage: issue the next buffer word, channel-major order.
                        if (issue) begin
                            r_valid <= 1'b1;
                            r_last  <= issue_last;
                            if (rd_word == AW'(DEPTH - 1)) begin
                                rd_word <= '0;
                                if (rd_ch == CW'(N_CH - 1)) begin
                                    rd_all <= 1'b1;
                                end else begin
                                    rd_ch <= rd_ch + 1'b1;
                                end
                            end else begin
                                rd_word <= rd_word + 1'b1;
                            end
                        end else if (out_load) begin
                            r_valid <= 1'b0;
                        end
                        // Output stage: tdata/tlast only change when the register is free.
                        if (out_load) begin
                            m_axis_tvalid <= r_valid;
                            if (r_valid) begin
                                m_axis_tdata <= ram_q;
                                m_axis_tlast <= r_last;
                            end else begin
                                m_axis_tlast <= 1'b0;
                            end
                        end
                        if (final_hs) begin
                            state         <= S_IDLE;
                            done          <= 1'b1;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - scoreboard testbench for adc_capture
module tb_adc_capture;

    localparam int N_CH = 2;
    localparam int SW   = 16;
    localparam int P    = 16;
    localparam int D    = 16;
    localparam int AW   = 4;
    localparam int CHW  = P * SW;
    localparam int MAXB = 512;

    logic                clk;
    logic                rst_n;
    logic [N_CH*CHW-1:0] s_tdata;
    logic                s_tvalid;
    logic                s_tready;
    logic                arm;
    logic                abort;
    logic [SW-1:0]       threshold;
    logic [0:0]          trig_ch;
    logic [AW-1:0]       pretrig;
    logic [CHW-1:0]      m_tdata;
    logic                m_tvalid;
    logic                m_tlast;
    logic                m_tready;
    logic                busy;
    logic                triggered;
    logic                done;

    adc_capture #(
        .N_CH(N_CH), .SAMPLE_WIDTH(SW), .PARALLEL(P), .DEPTH(D)
    ) dut (
        .s0_axis_adc_aclk(clk),
        .s0_axis_adc_aresetn(rst_n),
        .s_axis_adc_tdata(s_tdata),
        .s_axis_adc_tvalid(s_tvalid),
        .s_axis_adc_tready(s_tready),
        .arm(arm),
        .abort(abort),
        .threshold(threshold),
        .trig_ch(trig_ch),
        .pretrig(pretrig),
        .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready),
        .busy(busy),
        .triggered(triggered),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CHW-1:0] data;
        logic           last;
    } exp_t;

    exp_t           expq[$];
    logic [CHW-1:0] bd [N_CH][MAXB];
    int             checks = 0;
    int             passes = 0;
    int             hs_cnt = 0;
    int             done_cnt = 0;
    int             tready_pct = 100;
    logic           stall_prev = 1'b0;
    logic [CHW-1:0] held_data;
    logic           held_last;

    task automatic chk(input string name, input logic [CHW-1:0] got, input logic [CHW-1:0] expv);
        checks++;
        if (got === expv) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, expv);
    endtask

    // Monitor: pops the scoreboard on every handshake, checks AXIS hold rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && m_tvalid) begin
                chk("stall_tdata_hold", m_tdata, held_data);
                chk("stall_tlast_hold", m_tlast, held_last);
            end
            if (m_tvalid && m_tready) begin
                hs_cnt++;
                chk("beat_expected", (expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("readout_tdata", m_tdata, e.data);
                    chk("readout_tlast", m_tlast, e.last);
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_low_with_done", busy, 0);
            end
            stall_prev = m_tvalid && !m_tready;
            held_data  = m_tdata;
            held_last  = m_tlast;
        end
    end

    // Random downstream back-pressure.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = ($urandom_range(0, 99) < tready_pct);
        end
    end

    function automatic logic [CHW-1:0] gen_word(input int mode, input int k, input int ch);
        logic [CHW-1:0] w;
        logic [SW-1:0]  v;
        w = '0;
        for (int i = 0; i < P; i++) begin
            case (mode)
                0: v = (ch == 0) ? 16'(10 * k) : 16'(-k);
                1: begin
                    if (ch == 1) v = 16'(1000);
                    else if (i != 15 || k < 6 || k > 8) v = 16'(-100);
                    else if (k < 8) v = 16'(-5);
                    else v = 16'(-4);
                end
                default: v = 16'($urandom_range(0, 99) - 50);
            endcase
            w[i*SW +: SW] = v;
        end
        return w;
    endfunction

    function automatic bit crosses(input int k, input int tch, input logic signed [SW-1:0] thr);
        logic [CHW-1:0] w;
        w = bd[tch][k];
        for (int i = 0; i < P; i++) begin
            if ($signed(w[i*SW +: SW]) > thr) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_tready"}, s_tready, 0);
        chk({tag, "_m_tvalid"}, m_tvalid, 0);
        chk({tag, "_m_tlast"}, m_tlast, 0);
        chk({tag, "_m_tdata"}, m_tdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_triggered"}, triggered, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // action: 0 full capture, 1 abort in POST, 2 abort at readout beat 5, 3 reset at readout beat 5
    task automatic run_capture(input int mode, input int p, input logic signed [SW-1:0] thr,
                               input int tch, input int vpct, input int rpct, input int action);
        int k;
        int trig;
        int base_done;
        int base_hs;
        int n;
        bit pushed;
        tready_pct = rpct;
        base_done  = done_cnt;
        threshold  = thr;
        trig_ch    = 1'(tch);
        pretrig    = 4'(p);
        arm        = 1'b1;
        s_tvalid   = 1'b0;
        cyc(1);
        arm       = 1'b0;
        threshold = 16'h7fff;
        trig_ch   = ~trig_ch;
        pretrig   = ~pretrig;
        chk("busy_after_arm", busy, 1);
        chk("triggered_clear_after_arm", triggered, 0);
        k      = 0;
        trig   = -1;
        pushed = 1'b0;
        for (int c = 0; c < 600 && !pushed; c++) begin
            if (action == 1 && trig >= 0) break;
            if ($urandom_range(0, 99) < vpct && k < MAXB) begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    bd[ch][k] = gen_word(mode, k, ch);
                    s_tdata[ch*CHW +: CHW] = bd[ch][k];
                end
                s_tvalid = 1'b1;
                if (trig < 0 && k >= p && crosses(k, tch, thr)) trig = k;
                k++;
            end else begin
                s_tvalid = 1'b0;
                for (int i = 0; i < N_CH * P; i++) s_tdata[i*SW +: SW] = 16'h7fff;
            end
            // A second arm while busy must not disturb the capture.
            arm = (c == 3);
            if (trig >= 0 && k == trig + D - p) begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    for (int i = 0; i < D; i++) begin
                        exp_t e;
                        e.data = bd[ch][trig - p + i];
                        e.last = (ch == N_CH - 1) && (i == D - 1);
                        expq.push_back(e);
                    end
                end
                pushed = 1'b1;
            end
            cyc(1);
        end
        arm      = 1'b0;
        s_tvalid = 1'b0;
        chk("trigger_found", (trig >= 0), 1);
        base_hs = hs_cnt;
        case (action)
            0: begin
                n = 0;
                while (done_cnt == base_done && n < 3000) begin
                    cyc(1);
                    n++;
                end
                chk("done_seen", done_cnt - base_done, 1);
                chk("scoreboard_empty", expq.size(), 0);
                chk("busy_after_done", busy, 0);
                chk("triggered_after_done", triggered, 1);
                chk("tvalid_after_done", m_tvalid, 0);
                cyc(5);
                chk("done_single_pulse", done_cnt - base_done, 1);
            end
            1: begin
                chk("busy_in_post", busy, 1);
                abort = 1'b1;
                cyc(1);
                abort = 1'b0;
                chk("abort_post_tvalid", m_tvalid, 0);
                chk("abort_post_busy", busy, 0);
                chk("abort_post_triggered", triggered, 0);
                cyc(40);
                chk("abort_post_no_done", done_cnt - base_done, 0);
                chk("abort_post_no_beats", hs_cnt - base_hs, 0);
            end
            default: begin
                n = 0;
                while (hs_cnt < base_hs + 5 && n < 3000) begin
                    cyc(1);
                    n++;
                end
                chk("reached_beat5", (hs_cnt >= base_hs + 5), 1);
                if (action == 2) begin
                    abort = 1'b1;
                    cyc(1);
                    abort = 1'b0;
                    chk("abort_ro_tvalid", m_tvalid, 0);
                    chk("abort_ro_tlast", m_tlast, 0);
                    chk("abort_ro_busy", busy, 0);
                    chk("abort_ro_triggered", triggered, 0);
                    expq.delete();
                    cyc(40);
                    chk("abort_ro_no_done", done_cnt - base_done, 0);
                end else begin
                    #1;
                    rst_n = 1'b0;
                    #1;
                    check_reset_vals("async_reset");
                    expq.delete();
                    cyc(2);
                    chk("reset_hold_busy", busy, 0);
                    rst_n = 1'b1;
                    cyc(1);
                    chk("tready_after_reset", s_tready, 1);
                    chk("reset_ro_no_done", done_cnt - base_done, 0);
                end
            end
        endcase
    endtask

    initial begin
        rst_n     = 1'b0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        arm       = 1'b0;
        abort     = 1'b0;
        threshold = '0;
        trig_ch   = '0;
        pretrig   = '0;
        cyc(3);
        check_reset_vals("reset");
        rst_n = 1'b1;
        cyc(1);
        chk("tready_after_release", s_tready, 1);

        run_capture(0, 4, 16'sd100, 0, 100, 100, 0);
        run_capture(1, 4, -16'sd5, 0, 100, 100, 0);
        run_capture(0, 0, 16'sd100, 0, 100, 100, 0);
        run_capture(0, 15, 16'sd100, 0, 100, 100, 0);
        for (int r = 0; r < 4; r++) begin
            run_capture(2, $urandom_range(0, 15), 16'sd45, $urandom_range(0, 1), 60, 50, 0);
        end
        run_capture(0, 4, 16'sd100, 0, 100, 100, 1);
        run_capture(0, 6, 16'sd100, 0, 80, 70, 0);
        run_capture(0, 4, 16'sd100, 0, 100, 100, 2);
        run_capture(2, 3, 16'sd45, 1, 70, 60, 0);
        run_capture(0, 4, 16'sd100, 0, 100, 60, 3);

        arm   = 1'b1;
        abort = 1'b1;
        cyc(1);
        arm   = 1'b0;
        abort = 1'b0;
        chk("arm_abort_idle_busy", busy, 0);
        pretrig = 4'd4;
        arm     = 1'b1;
        cyc(1);
        chk("arm_busy", busy, 1);
        abort = 1'b1;
        cyc(1);
        arm   = 1'b0;
        abort = 1'b0;
        chk("arm_abort_busy", busy, 0);
        cyc(2);
        chk("stays_idle", busy, 0);

        run_capture(0, 2, 16'sd100, 0, 100, 100, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
